// File: rtl/string_gen_if.sv
// string_gen bus: start controls in, serial frame and golden count out.
// master drives the start request; slave is the transmitter.
interface string_gen_if;
   logic        en;
   logic        mode;
   logic [15:0] sw;
   logic        bit_out;
   logic        bit_valid;
   logic        busy;
   logic        done;
   logic [4:0]  expected_count;

   modport master (
      output en, mode, sw,
      input  bit_out, bit_valid, busy, done, expected_count
   );

   modport slave (
      input  en, mode, sw,
      output bit_out, bit_valid, busy, done, expected_count
   );
endinterface

// File: rtl/string_gen.sv
// Serial pattern transmitter: sends a 16-bit word LSB-first and
// counts overlapping PATTERN matches as a golden reference.
module string_gen #(
   parameter int unsigned        PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1001,
   parameter logic [15:0]        LFSR_SEED = 16'hACE1
) (
   input logic         clk,
   input logic         clr,
   string_gen_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [15:0]        shreg_q, shreg_d;
   logic [3:0]         idx_q, idx_d;
   logic [PAT_LEN-1:0] win_q, win_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               bit_q, bit_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [15:0]        lfsr_nx;
   logic [15:0]        word;
   logic [PAT_LEN-1:0] win_nx;

   assign lfsr_nx = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign win_nx  = {win_q[PAT_LEN-2:0], bit_q};

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      bit_d   = bit_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      word    = bus.mode ? lfsr_q : bus.sw;
      unique case (state_q)
         IDLE: begin
            if (bus.en) begin
               // bit 0 goes straight to the output register
               shreg_d = {1'b0, word[15:1]};
               bit_d   = word[0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               idx_d   = 4'd0;
               win_d   = '0;
               cnt_d   = 5'd0;
               if (bus.mode)
                  lfsr_d = lfsr_nx;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            win_d = win_nx;
            if (win_nx == PATTERN && idx_q >= 4'(PAT_LEN - 1))
               cnt_d = cnt_q + 5'd1;
            if (idx_q == 4'd15) begin
               bit_d   = 1'b0;
               valid_d = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               bit_d   = shreg_q[0];
               shreg_d = {1'b0, shreg_q[15:1]};
               idx_d   = idx_q + 4'd1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         win_q   <= '0;
         cnt_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         bit_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.bit_out        = bit_q;
   assign bus.bit_valid      = valid_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.expected_count = cnt_q;

endmodule

// File: tb/tb_string_gen.sv
// Directed bench for string_gen: fixed frames with hand-computed
// bit streams and match counts, checked one cycle after each edge.
module tb_string_gen;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   ncmp = 0;
   int   nerr = 0;

   string_gen_if sg ();

   string_gen dut (
      .clk (clk),
      .clr (clr),
      .bus (sg)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [4:0] cnt);
      chk({tag, ".valid"}, 32'(sg.bit_valid), 32'd0);
      chk({tag, ".bit"}, 32'(sg.bit_out), 32'd0);
      chk({tag, ".busy"}, 32'(sg.busy), 32'd0);
      chk({tag, ".done"}, 32'(sg.done), 32'd0);
      chk({tag, ".cnt"}, 32'(sg.expected_count), 32'(cnt));
   endtask

   // starts in cycle k+1; ends in cycle k+18 (idle after done)
   task automatic chk_frame(input string tag, input logic [15:0] word,
                            input logic [4:0] cnt, input bit chg_sw);
      for (int i = 0; i < 16; i++) begin
         if (chg_sw && i == 5)
            sg.sw = 16'hFFFF;
         chk($sformatf("%s.bit%0d", tag, i), 32'(sg.bit_out),
             32'(word[i]));
         chk($sformatf("%s.val%0d", tag, i), 32'(sg.bit_valid), 32'd1);
         chk($sformatf("%s.busy%0d", tag, i), 32'(sg.busy), 32'd1);
         chk($sformatf("%s.ndone%0d", tag, i), 32'(sg.done), 32'd0);
         step();
      end
      chk({tag, ".done"}, 32'(sg.done), 32'd1);
      chk({tag, ".dbusy"}, 32'(sg.busy), 32'd1);
      chk({tag, ".dval"}, 32'(sg.bit_valid), 32'd0);
      chk({tag, ".dbit"}, 32'(sg.bit_out), 32'd0);
      chk({tag, ".cnt"}, 32'(sg.expected_count), 32'(cnt));
      step();
      chk_idle({tag, ".after"}, cnt);
   endtask

   task automatic start(input logic m, input logic [15:0] w);
      sg.en   = 1'b1;
      sg.mode = m;
      sg.sw   = w;
      step();
      sg.en   = 1'b0;
      sg.sw   = 16'h0000;
   endtask

   initial begin
      sg.en   = 1'b0;
      sg.mode = 1'b0;
      sg.sw   = 16'h0000;
      clr     = 1'b1;
      step();
      step();
      chk_idle("rst", 5'd0);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk_idle("idle", 5'd0);

      start(1'b0, 16'h9999);
      chk_frame("f9999", 16'h9999, 5'd4, 1'b0);
      start(1'b0, 16'h0249);
      chk_frame("f0249", 16'h0249, 5'd3, 1'b0);
      start(1'b0, 16'hFFFF);
      chk_frame("fFFFF", 16'hFFFF, 5'd0, 1'b0);
      start(1'b0, 16'h0000);
      chk_frame("f0000", 16'h0000, 5'd0, 1'b0);

      // en held high: 9999 frame, sw changes mid-frame, restart at +18
      sg.en   = 1'b1;
      sg.mode = 1'b0;
      sg.sw   = 16'h9999;
      step();
      chk_frame("hold1", 16'h9999, 5'd4, 1'b1);
      step();
      sg.en = 1'b0;
      chk_frame("hold2", 16'hFFFF, 5'd0, 1'b0);

      start(1'b1, 16'h0000);
      chk_frame("lfsr1", 16'hACE1, 5'd1, 1'b0);
      start(1'b1, 16'h0000);
      chk_frame("lfsr2", 16'h59C3, 5'd1, 1'b0);

      // abort at bit 7, then LFSR must be back at the seed
      start(1'b0, 16'h9999);
      for (int i = 0; i < 7; i++) step();
      chk("abort.bit7", 32'(sg.bit_out), 32'd1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk_idle("abort", 5'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk($sformatf("abort.nodone%0d", i), 32'(sg.done), 32'd0);
      end
      start(1'b1, 16'h0000);
      chk_frame("lfsr3", 16'hACE1, 5'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/string_gen.md
# string_gen

Serial pattern transmitter: the source end of the serial sequence-recognition path. On a start strobe it captures a 16-bit word, either the switch value or the next word of an internal LFSR. It then shifts the word out LSB-first, one bit per clock, with a valid qualifier. While shifting it computes the golden count of overlapping occurrences of a target pattern in the transmitted frame, so the downstream recognizer can be self-checked on the board.

## Interface
Parameters:
- PATTERN, 4'b1001: target sequence, oldest bit = PATTERN[PAT_LEN-1].
- PAT_LEN, 4: pattern length, legal range 2..8.
- LFSR_SEED, 16'hACE1: LFSR value after reset; must be nonzero.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- en  in  1  start strobe, sampled only in IDLE.
- sw  in  16  frame word for mode 0.
- mode  in  1  0 = transmit sw, 1 = transmit LFSR word; sampled with en.
- bit_out  out  1  serial data, LSB first.
- bit_valid  out  1  high exactly while bit_out carries a frame bit.
- busy  out  1  high from the cycle after start through the done cycle.
- done  out  1  one-cycle pulse after the last bit.
- expected_count  out  5  overlapping PATTERN matches in the last frame.

## Operation
- Reset (clr=1 at an edge) sets, on the next cycle:
  - state = IDLE; bit_out, bit_valid, busy, done = 0; expected_count = 0;
  - shift register = 0, bit index = 0, match window = 0;
  - LFSR = LFSR_SEED.
- clr has priority over every other input, including mid-frame: the frame is aborted with no done pulse.
- States:
  - IDLE: en=1 captures the word (sw, or the current LFSR value) into the shift register. Clears the bit index, match window and expected_count. If mode=1, advances the LFSR one step in the same edge. Goes to SHIFT. en=0 stays in IDLE.
  - SHIFT: each cycle presents shreg[0] on bit_out with bit_valid=1, then shifts right. After the 16th bit goes to DONE.
  - DONE: done=1, busy=1, bit_valid=0, bit_out=0. Goes to IDLE next cycle.
- en is ignored in SHIFT and DONE; no queuing. A new frame can start on the cycle after DONE.
- mode and sw are don't-care outside the capture edge.
- LFSR (Fibonacci, x^16+x^14+x^13+x^11+1):
  - next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]};
  - advances only on mode-1 starts and never reaches 0.
- Match counting:
  - window <= {window[PAT_LEN-2:0], bit} on each transmitted bit.
  - Match when window[PAT_LEN-1:0] == PATTERN and at least PAT_LEN bits of the current frame have been sent. Window contents from a previous frame never count.
  - Overlapping matches count. expected_count increments by 1 per match.
  - Maximum is 17-PAT_LEN, so 5 bits never wrap.
- expected_count is final when done=1. It holds until the next capture edge or clr.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Capture edge = edge k with en=1 in IDLE.
- Bit i (i = 0..15) is valid in cycle k+1+i, with bit_out = word[i].
- done is high in cycle k+17; IDLE from cycle k+18. Back-to-back frames have period 18 cycles.
- busy is high cycles k+1..k+17.
- The expected_count update for bit i is visible in cycle k+2+i. The final value is visible at the latest in the done cycle.
- clr at edge m: all outputs at reset values from cycle m+1.

## Test plan
- Reset then idle: clr high for 2 cycles, en=0 -> bit_valid, busy, done, expected_count stay 0; LFSR = 16'hACE1.
- Mode 0, sw=16'h9999, en pulse -> 16 valid bits 1,0,0,1 repeated four times; done one cycle at k+17; expected_count=4.
- Overlap: sw=16'h0249 -> stream 1001001001000000; expected_count=3. sw=16'hFFFF -> 0. sw=16'h0000 -> 0.
- LFSR mode: two consecutive mode-1 frames -> first transmits 16'hACE1, second transmits 16'h59C3 (one LFSR step).
- en held high continuously during a frame -> no restart; frames occur every 18 cycles; sw change mid-frame has no effect on bit_out.
- clr at bit 7 of a frame -> outputs 0 next cycle, no done pulse; a subsequent mode-1 frame transmits 16'hACE1.
